// File: rtl/wdt_pkg.sv
// ============================================================================
//  Module      : wdt_pkg
//  Description : Shared constants and types for the two-stage watchdog:
//                register word indices, CTRL/STATUS bit positions, the
//                stage FSM state type and the default kick key.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wdt_pkg;

  // Register word indices (byte offset [4:2])
  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_LOAD   = 3'd1;
  localparam logic [2:0] IDX_COUNT  = 3'd2;
  localparam logic [2:0] IDX_KICK   = 3'd3;
  localparam logic [2:0] IDX_STATUS = 3'd4;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_RST_EN  = 2;
  localparam int CTRL_LOCK    = 3;
  localparam int CTRL_DIV_LSB = 4;

  // STATUS bit positions
  localparam int STAT_IRQ_PEND = 0;
  localparam int STAT_BAD_KICK = 1;
  localparam int STAT_WDT_RST  = 2;
  localparam int STAT_STAGE2   = 3;

  // Default service key
  localparam logic [31:0] KICK_KEY_DEFAULT = 32'h5A5A_A5A5;

  // Watchdog stage FSM
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COUNT1      = 2'd1,
    COUNT2      = 2'd2,
    RST_PULSE_S = 2'd3
  } wdt_state_t;

endpackage

`default_nettype wire

// File: rtl/wdt_prescaler.sv
// ============================================================================
//  Module      : wdt_prescaler
//  Description : Divide-by-(div+1) tick generator for the watchdog counter.
//                Held at zero while disabled or when cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wdt_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;

  // A tick fires on the last cycle of each div+1 cycle window
  assign tick = enable && (r_cnt == div);

  // Prescale counter: restarts on clear, idles at zero when disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear || !enable) begin
      r_cnt <= '0;
    end else if (r_cnt == div) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/wdt_controller.sv
// ============================================================================
//  Module      : wdt_controller
//  Description : Memory-mapped two-stage watchdog. Stage 1 expiry raises an
//                interrupt, stage 2 expiry emits a fixed-length reset pulse.
//                Sticky status survives the watchdog's own reset pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wdt_controller
  import wdt_pkg::*;
#(
  parameter int          CNT_W     = 32,
  parameter int          DIV_W     = 8,
  parameter logic [31:0] KICK_KEY  = KICK_KEY_DEFAULT,
  parameter int          RST_PULSE = 4,
  parameter logic [31:0] LOAD_RST  = 32'h0000_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        wdt_irq,
  output logic        wdt_reset
);

  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  // Architectural state
  wdt_state_t       state, state_nxt;
  logic             ctrl_en, ctrl_irq_en, ctrl_rst_en, ctrl_lock;
  logic [DIV_W-1:0] ctrl_div;
  logic [CNT_W-1:0] load, count;
  logic             irq_pend, bad_kick, wdt_rst, stage2;
  logic [PW-1:0]    pulse_cnt;

  // Decoded events
  logic [2:0]       idx;
  logic             wr, rd, ctrl_wr, load_wr, kick_wr, status_wr;
  logic             counting, en_on, en_off, kick_hit, kick_bad;
  logic             expire, take_expire, pulse_done;
  logic             reload, dec, irq_set, stage2_set, stage2_clr, wdt_rst_set;
  logic [CNT_W-1:0] load_eff;
  logic [31:0]      rd_mux;
  logic             tick;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];

  wdt_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (counting),
    .clear  (reload),
    .div    (ctrl_div),
    .tick   (tick)
  );

  // Bus decode and event arbitration: kick beats expiry, disable beats both
  always_comb begin
    idx        = req_addr[4:2];
    wr         = req_valid && req_we;
    rd         = req_valid && !req_we;
    ctrl_wr    = wr && (idx == IDX_CTRL) && !ctrl_lock;
    load_wr    = wr && (idx == IDX_LOAD) && !ctrl_lock;
    kick_wr    = wr && (idx == IDX_KICK);
    status_wr  = wr && (idx == IDX_STATUS);
    counting   = (state == COUNT1) || (state == COUNT2);
    en_on      = ctrl_wr && req_wdata[CTRL_EN] && (state == IDLE);
    en_off     = ctrl_wr && !req_wdata[CTRL_EN] && counting;
    kick_hit   = kick_wr && counting && (req_wdata == KICK_KEY);
    kick_bad   = kick_wr && counting && (req_wdata != KICK_KEY);
    expire     = counting && tick && (count <= CNT_W'(1));
    take_expire = expire && !kick_hit && !en_off;
    pulse_done = (state == RST_PULSE_S) && (pulse_cnt == PW'(RST_PULSE - 1));
    load_eff   = (load == '0) ? CNT_W'(1) : load;
    // Entering the reset pulse is the only expiry that does not reload
    reload     = en_on || kick_hit || (pulse_done && ctrl_en) ||
                 (take_expire && !((state == COUNT2) && ctrl_rst_en));
    dec        = counting && tick && !expire && !kick_hit && !en_off;
    irq_set    = take_expire && (state == COUNT1);
    stage2_set = take_expire && (state == COUNT1);
    stage2_clr = kick_hit || en_off || pulse_done;
    wdt_rst_set = take_expire && (state == COUNT2) && ctrl_rst_en;
  end

  // Stage FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (en_on) state_nxt = COUNT1;
      end
      COUNT1: begin
        if (en_off)        state_nxt = IDLE;
        else if (kick_hit) state_nxt = COUNT1;
        else if (expire)   state_nxt = COUNT2;
      end
      COUNT2: begin
        if (en_off)        state_nxt = IDLE;
        else if (kick_hit) state_nxt = COUNT1;
        else if (expire)   state_nxt = ctrl_rst_en ? RST_PULSE_S : COUNT2;
      end
      RST_PULSE_S: begin
        if (pulse_done) state_nxt = ctrl_en ? COUNT1 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage FSM outputs
  always_comb begin
    wdt_reset = (state == RST_PULSE_S);
    wdt_irq   = irq_pend && ctrl_irq_en;
  end

  // Reset pulse length counter, restarted whenever the pulse is not active
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_cnt <= '0;
    end else if (state != RST_PULSE_S) begin
      pulse_cnt <= '0;
    end else begin
      pulse_cnt <= pulse_cnt + PW'(1);
    end
  end

  // CTRL and LOAD registers; LOCK is sticky until external reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_rst_en <= 1'b0;
      ctrl_lock   <= 1'b0;
      ctrl_div    <= '0;
      load        <= CNT_W'(LOAD_RST);
    end else begin
      if (ctrl_wr) begin
        ctrl_en     <= req_wdata[CTRL_EN];
        ctrl_irq_en <= req_wdata[CTRL_IRQ_EN];
        ctrl_rst_en <= req_wdata[CTRL_RST_EN];
        ctrl_lock   <= ctrl_lock | req_wdata[CTRL_LOCK];
        ctrl_div    <= req_wdata[CTRL_DIV_LSB +: DIV_W];
      end
      if (load_wr) begin
        load <= req_wdata[CNT_W-1:0];
      end
    end
  end

  // Down-counter: a reload samples LOAD before any same-edge LOAD write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (reload) begin
      count <= load_eff;
    end else if (dec) begin
      count <= count - CNT_W'(1);
    end
  end

  // Sticky status bits: a hardware set wins over a same-edge W1C
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_pend <= 1'b0;
      bad_kick <= 1'b0;
      wdt_rst  <= 1'b0;
      stage2   <= 1'b0;
    end else begin
      irq_pend <= irq_set     || (irq_pend && !(status_wr && req_wdata[STAT_IRQ_PEND]));
      bad_kick <= kick_bad    || (bad_kick && !(status_wr && req_wdata[STAT_BAD_KICK]));
      wdt_rst  <= wdt_rst_set || (wdt_rst  && !(status_wr && req_wdata[STAT_WDT_RST]));
      if (stage2_set) begin
        stage2 <= 1'b1;
      end else if (stage2_clr) begin
        stage2 <= 1'b0;
      end
    end
  end

  // Read data mux
  always_comb begin
    rd_mux = 32'h0;
    case (idx)
      IDX_CTRL:   rd_mux = {{(32 - CTRL_DIV_LSB - DIV_W){1'b0}}, ctrl_div,
                            ctrl_lock, ctrl_rst_en, ctrl_irq_en, ctrl_en};
      IDX_LOAD:   rd_mux = 32'(load);
      IDX_COUNT:  rd_mux = 32'(count);
      IDX_STATUS: rd_mux = {28'h0, stage2, wdt_rst, bad_kick, irq_pend};
      default:    rd_mux = 32'h0;
    endcase
  end

  // Registered read response; rdata holds between reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata  <= 32'h0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd;
      if (rd) begin
        rdata <= rd_mux;
      end
    end
  end

endmodule

`default_nettype wire
